// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding CPU load/store bridge to a
// fixed-latency word memory, with optional address checking.
// Params : DEPTH_WORDS (memory words), RD_LAT (read latency 1..3)
// Ports  : Clock, Reset (sync, active-high)
//          Req_Valid/Req_Ready/Req_Write/Req_Addr/Req_WData  CPU request
//          Resp_Valid/Resp_Ready/Resp_RData/Resp_Err         CPU response
//          Mem_Addr/Mem_En_R/Mem_En_W/Mem_Data_W/Mem_Data_R  memory side
//          Err_Count  saturating count of errored requests
// Macro  : MEM_ADDR_CHECK_EN enables misalign/range error detection.
module mem_access_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int RD_LAT      = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_Write,
  input  logic [31:0] Req_Addr,
  input  logic [31:0] Req_WData,
  output logic        Resp_Valid,
  input  logic        Resp_Ready,
  output logic [31:0] Resp_RData,
  output logic        Resp_Err,
  output logic [29:0] Mem_Addr,
  output logic        Mem_En_R,
  output logic        Mem_En_W,
  output logic [31:0] Mem_Data_W,
  input  logic [31:0] Mem_Data_R,
  output logic [7:0]  Err_Count
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RESP
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [7:0]  r_err_cnt;
  logic        w_err;
  logic        w_accept;

`ifdef MEM_ADDR_CHECK_EN
  assign w_err = (Req_Addr[1:0] != 2'b00) ||
                 ({2'b00, Req_Addr[31:2]} >= 32'(DEPTH_WORDS));
`else
  logic w_unused;
  assign w_err    = 1'b0;
  assign w_unused = ^{Req_Addr[1:0], 32'(DEPTH_WORDS)};
`endif

  assign Req_Ready  = (r_state == IDLE) && !Reset;
  assign w_accept   = Req_Valid && Req_Ready;
  assign Mem_Addr   = Req_Addr[31:2];
  assign Mem_Data_W = Req_WData;
  assign Mem_En_W   = w_accept && Req_Write && !w_err;
  assign Mem_En_R   = w_accept && !Req_Write && !w_err;
  assign Resp_Valid = (r_state == RESP);
  assign Resp_RData = r_rdata;
  assign Resp_Err   = r_err;
  assign Err_Count  = r_err_cnt;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          // stores and rejected requests answer next cycle
          if (Req_Write || w_err) w_next = RESP;
          else                    w_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (r_cnt == LAT_M1) w_next = RESP;
      end
      RESP: begin
        if (Resp_Ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_cnt     <= 2'd0;
      r_rdata   <= 32'd0;
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= 2'd0;
        r_rdata <= 32'd0;
        r_err   <= w_err;
        if (w_err && r_err_cnt != 8'hFF)
          r_err_cnt <= r_err_cnt + 8'd1;
      end
      // last wait cycle is when memory presents the read data
      if (r_state == RD_WAIT) begin
        if (r_cnt == LAT_M1) r_rdata <= Mem_Data_R;
        else                 r_cnt   <= r_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: self-checking bench for mem_access_ctrl with a
// latency-accurate memory model and a word-level shadow reference.
module tb_mem_access_ctrl;

  localparam int DW = 256;
  localparam int RL = 2;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Req_Valid;
  logic        Req_Ready;
  logic        Req_Write;
  logic [31:0] Req_Addr;
  logic [31:0] Req_WData;
  logic        Resp_Valid;
  logic        Resp_Ready;
  logic [31:0] Resp_RData;
  logic        Resp_Err;
  logic [29:0] Mem_Addr;
  logic        Mem_En_R;
  logic        Mem_En_W;
  logic [31:0] Mem_Data_W;
  logic [31:0] Mem_Data_R;
  logic [7:0]  Err_Count;

  int errors = 0;
  int checks = 0;
  int n_err  = 0;

  bit [31:0] shadow [int];

  always #5 Clock = ~Clock;

  mem_access_ctrl #(.DEPTH_WORDS(DW), .RD_LAT(RL)) dut (
    .Clock(Clock), .Reset(Reset),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .Req_Write(Req_Write), .Req_Addr(Req_Addr),
    .Req_WData(Req_WData),
    .Resp_Valid(Resp_Valid), .Resp_Ready(Resp_Ready),
    .Resp_RData(Resp_RData), .Resp_Err(Resp_Err),
    .Mem_Addr(Mem_Addr), .Mem_En_R(Mem_En_R),
    .Mem_En_W(Mem_En_W), .Mem_Data_W(Mem_Data_W),
    .Mem_Data_R(Mem_Data_R), .Err_Count(Err_Count)
  );

  // memory device: data appears only during cycle RL after the read
  logic [31:0] mem [DW];
  logic [2:0]  pv;
  logic [31:0] pd [3];

  always @(posedge Clock) begin
    if (Mem_En_W) mem[Mem_Addr[7:0]] <= Mem_Data_W;
    if (Reset) pv <= 3'b000;
    else       pv <= {pv[1:0], Mem_En_R};
    pd[2] <= pd[1];
    pd[1] <= pd[0];
    pd[0] <= mem[Mem_Addr[7:0]];
  end

  assign Mem_Data_R = pv[RL-1] ? pd[RL-1] : 32'hBAD0BAD0;

  task automatic drive_junk(input bit junk);
    Req_Valid = junk;
    if (junk) begin
      Req_Write = 1'($urandom);
      Req_Addr  = $urandom;
      Req_WData = $urandom;
    end
  endtask

  task automatic issue(
    input  bit        wr,
    input  bit [31:0] a,
    input  bit [31:0] d,
    input  int        hold,
    input  bit        junk,
    output bit        rdy0,
    output bit        enr,
    output bit        enw,
    output bit [29:0] ma,
    output int        lat,
    output bit [31:0] rd,
    output bit        er,
    output bit        stable,
    output bit        stray,
    output bit        rdy_after
  );
    @(negedge Clock);
    Req_Valid = 1'b1;
    Req_Write = wr;
    Req_Addr  = a;
    Req_WData = d;
    #1;
    rdy0 = Req_Ready;
    enr  = Mem_En_R;
    enw  = Mem_En_W;
    ma   = Mem_Addr;
    stray  = 1'b0;
    stable = 1'b1;
    @(negedge Clock);
    drive_junk(junk);
    #1;
    lat = 1;
    while (!Resp_Valid && lat < 20) begin
      if (Mem_En_R || Mem_En_W || Req_Ready) stray = 1'b1;
      @(negedge Clock);
      drive_junk(junk);
      #1;
      lat++;
    end
    rd = Resp_RData;
    er = Resp_Err;
    if (Mem_En_R || Mem_En_W || Req_Ready) stray = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge Clock);
      drive_junk(junk);
      #1;
      if (!Resp_Valid || Resp_RData !== rd || Resp_Err !== er ||
          Req_Ready !== 1'b0 || Mem_En_R || Mem_En_W)
        stable = 1'b0;
    end
    Resp_Ready = 1'b1;
    @(negedge Clock);
    Req_Valid  = 1'b0;
    Resp_Ready = 1'b0;
    #1;
    rdy_after = Req_Ready && !Resp_Valid;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Req_Valid = 1'b1;
    Req_Write = 1'b0;
    Req_Addr = 32'h10;
    Req_WData = 32'h0;
    Resp_Ready = 1'b0;
    repeat (2) @(negedge Clock);
    #1;
    checks++;
    if (Req_Ready !== 1'b0 || Mem_En_R !== 1'b0 || Mem_En_W !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: rdy=%b enr=%b enw=%b want 0 0 0",
               Req_Ready, Mem_En_R, Mem_En_W);
    end
    checks++;
    if (Resp_Valid !== 1'b0 || Resp_Err !== 1'b0 ||
        Resp_RData !== 32'd0 || Err_Count !== 8'd0) begin
      errors++;
      $display("FAIL reset_resp: v=%b e=%b d=%h cnt=%0d want 0 0 0 0",
               Resp_Valid, Resp_Err, Resp_RData, Err_Count);
    end
    @(negedge Clock);
    Req_Valid = 1'b0;
    Reset = 1'b0;
    #1;
    checks++;
    if (Req_Ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy: got %b want 1", Req_Ready);
    end
  endtask

  task automatic test_store_load();
    bit r0, er_, ew, er, st, sy, ra;
    bit [29:0] ma;
    bit [31:0] rd;
    int lat;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0,
          r0, er_, ew, ma, lat, rd, er, st, sy, ra);
    shadow[4] = 32'hDEADBEEF;
    checks++;
    if (!r0 || !ew || er_ || ma !== 30'd4) begin
      errors++;
      $display("FAIL store_c0: rdy=%b enw=%b enr=%b ma=%0d want 1 1 0 4",
               r0, ew, er_, ma);
    end
    checks++;
    if (lat != 1 || er || rd !== 32'd0) begin
      errors++;
      $display("FAIL store_resp: lat=%0d err=%b d=%h want 1 0 0",
               lat, er, rd);
    end
    issue(1'b0, 32'h10, 32'h0, 0, 1'b0,
          r0, er_, ew, ma, lat, rd, er, st, sy, ra);
    checks++;
    if (!er_ || ew || ma !== 30'd4) begin
      errors++;
      $display("FAIL load_c0: enr=%b enw=%b ma=%0d want 1 0 4",
               er_, ew, ma);
    end
    checks++;
    if (lat != RL + 1 || rd !== 32'hDEADBEEF || er) begin
      errors++;
      $display("FAIL load_resp: lat=%0d d=%h err=%b want %0d deadbeef 0",
               lat, rd, er, RL + 1);
    end
  endtask

  task automatic test_backpressure();
    bit r0, er_, ew, er, st, sy, ra;
    bit [29:0] ma;
    bit [31:0] rd;
    int lat;
    issue(1'b0, 32'h10, 32'h0, 5, 1'b1,
          r0, er_, ew, ma, lat, rd, er, st, sy, ra);
    checks++;
    if (!st || sy) begin
      errors++;
      $display("FAIL bp_hold: stable=%b stray=%b want 1 0", st, sy);
    end
    checks++;
    if (!ra || rd !== shadow[4]) begin
      errors++;
      $display("FAIL bp_after: rdy_after=%b d=%h want 1 %h",
               ra, rd, shadow[4]);
    end
  endtask

  task automatic test_random();
    bit r0, er_, ew, er, st, sy, ra;
    bit [29:0] ma;
    bit [31:0] rd, d, exp_d;
    int lat, w, hold, exp_lat;
    bit wr;
    for (int it = 0; it < 40; it++) begin
      wr = 1'($urandom);
      w = int'($urandom_range(0, 15));
      if (!wr && !shadow.exists(w)) wr = 1'b1;
      d = $urandom;
      hold = int'($urandom_range(0, 3));
      exp_d = wr ? 32'd0 : shadow[w];
      exp_lat = wr ? 1 : RL + 1;
      issue(wr, 32'(w) << 2, d, hold, 1'($urandom),
            r0, er_, ew, ma, lat, rd, er, st, sy, ra);
      if (wr) shadow[w] = d;
      checks++;
      if (!r0 || ew !== wr || er_ !== !wr || ma !== 30'(w)) begin
        errors++;
        $display("FAIL rnd_c0[%0d]: rdy=%b enw=%b enr=%b ma=%0d want 1 %b %b %0d",
                 it, r0, ew, er_, ma, wr, !wr, w);
      end
      checks++;
      if (lat != exp_lat || rd !== exp_d || er) begin
        errors++;
        $display("FAIL rnd_resp[%0d]: lat=%0d d=%h err=%b want %0d %h 0",
                 it, lat, rd, er, exp_lat, exp_d);
      end
      checks++;
      if (!st || sy || !ra) begin
        errors++;
        $display("FAIL rnd_hs[%0d]: stable=%b stray=%b rdy_after=%b want 1 0 1",
                 it, st, sy, ra);
      end
    end
  endtask

`ifdef MEM_ADDR_CHECK_EN
  task automatic test_errors();
    bit r0, er_, ew, er, st, sy, ra;
    bit [29:0] ma;
    bit [31:0] rd, a, addrs [2];
    int lat, exp_cnt;
    addrs[0] = 32'h13;
    addrs[1] = 32'h400;
    for (int k = 0; k < 2; k++) begin
      issue(1'b0, addrs[k], 32'h0, 0, 1'b0,
            r0, er_, ew, ma, lat, rd, er, st, sy, ra);
      n_err++;
      checks++;
      if (er_ || ew || !er || lat != 1 || rd !== 32'd0) begin
        errors++;
        $display("FAIL err_req[%h]: enr=%b enw=%b err=%b lat=%0d d=%h want 0 0 1 1 0",
                 addrs[k], er_, ew, er, lat, rd);
      end
    end
    checks++;
    if (Err_Count !== 8'd2) begin
      errors++;
      $display("FAIL err_cnt2: got %0d want 2", Err_Count);
    end
    for (int k = 0; k < 298; k++) begin
      if ($urandom_range(0, 1) == 0)
        a = {24'($urandom_range(0, DW - 1)), 6'd0, 2'($urandom_range(1, 3))};
      else
        a = {30'($urandom_range(DW, 32'h3FFF_FFFF)), 2'b00};
      issue(1'($urandom), a, $urandom, 0, 1'b0,
            r0, er_, ew, ma, lat, rd, er, st, sy, ra);
      n_err++;
      exp_cnt = (n_err > 255) ? 255 : n_err;
      if (n_err == 254 || n_err == 255 || n_err == 256) begin
        checks++;
        if (Err_Count !== 8'(exp_cnt) || er_ || ew || !er) begin
          errors++;
          $display("FAIL err_sat[%0d]: cnt=%0d enr=%b enw=%b err=%b want %0d 0 0 1",
                   n_err, Err_Count, er_, ew, er, exp_cnt);
        end
      end
    end
    checks++;
    if (Err_Count !== 8'd255) begin
      errors++;
      $display("FAIL err_cnt300: got %0d want 255", Err_Count);
    end
  endtask
`else
  task automatic test_no_check();
    bit r0, er_, ew, er, st, sy, ra;
    bit [29:0] ma;
    bit [31:0] rd;
    int lat;
    issue(1'b0, 32'h13, 32'h0, 0, 1'b0,
          r0, er_, ew, ma, lat, rd, er, st, sy, ra);
    checks++;
    if (ma !== 30'd4 || !er_ || ew || er) begin
      errors++;
      $display("FAIL nochk_c0: ma=%0d enr=%b enw=%b err=%b want 4 1 0 0",
               ma, er_, ew, er);
    end
    checks++;
    if (rd !== shadow[4] || lat != RL + 1 || Err_Count !== 8'd0) begin
      errors++;
      $display("FAIL nochk_resp: d=%h lat=%0d cnt=%0d want %h %0d 0",
               rd, lat, Err_Count, shadow[4], RL + 1);
    end
  endtask
`endif

  task automatic test_reset_midload();
    bit seen;
    bit r0, er_, ew, er, st, sy, ra;
    bit [29:0] ma;
    bit [31:0] rd;
    int lat;
    @(negedge Clock);
    Req_Valid = 1'b1;
    Req_Write = 1'b0;
    Req_Addr  = 32'h10;
    @(negedge Clock);
    Req_Valid = 1'b0;
    Reset = 1'b1;
    #1;
    checks++;
    if (Req_Ready !== 1'b0 || Mem_En_R !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ctl: rdy=%b enr=%b want 0 0", Req_Ready, Mem_En_R);
    end
    @(negedge Clock);
    Reset = 1'b0;
    Resp_Ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (Resp_Valid) seen = 1'b1;
      @(negedge Clock);
    end
    Resp_Ready = 1'b0;
    #1;
    checks++;
    if (seen || Req_Ready !== 1'b1 || Err_Count !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid: resp_seen=%b rdy=%b cnt=%0d want 0 1 0",
               seen, Req_Ready, Err_Count);
    end
    issue(1'b0, 32'h10, 32'h0, 1, 1'b0,
          r0, er_, ew, ma, lat, rd, er, st, sy, ra);
    checks++;
    if (rd !== shadow[4] || lat != RL + 1 || !ra) begin
      errors++;
      $display("FAIL rst_post_load: d=%h lat=%0d rdy_after=%b want %h %0d 1",
               rd, lat, ra, shadow[4], RL + 1);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_backpressure();
    test_random();
`ifdef MEM_ADDR_CHECK_EN
    test_errors();
`else
    test_no_check();
`endif
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words in the data memory.
REQ-002 SHALL have parameter RD_LAT, default 2, data memory read latency in cycles (legal 1..3).
REQ-003 SHALL have port Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports Req_Valid/Req_Ready  input/output  1/1  CPU request handshake.
REQ-006 SHALL have ports Req_Write  input  1  1 = store, 0 = load.
REQ-007 SHALL have ports Req_Addr/Req_WData  input/input  32/32  byte address and store data.
REQ-008 SHALL have ports Resp_Valid/Resp_Ready  output/input  1/1  response handshake.
REQ-009 SHALL have ports Resp_RData/Resp_Err  output/output  32/1  load data and access-error flag.
REQ-010 SHALL have ports Mem_Addr  output  30  word address to data memory.
REQ-011 SHALL have ports Mem_En_R/Mem_En_W  output/output  1/1  memory read and write enables.
REQ-012 SHALL have ports Mem_Data_W/Mem_Data_R  output/input  32/32  memory write and read data.
REQ-013 SHALL have port Err_Count  output  8  saturating count of errored requests.

Function
REQ-014 SHALL implement FSM states IDLE, RD_WAIT and RESP.
REQ-015 SHALL drive Req_Ready = 1 only in IDLE with Reset low; a request is accepted in the cycle with Req_Valid & Req_Ready ("cycle 0").
REQ-016 SHALL drive Mem_Addr = Req_Addr[31:2] and Mem_Data_W = Req_WData combinationally in every cycle.
REQ-017 SHALL pulse Mem_En_W (store) or Mem_En_R (load) combinationally in cycle 0 only, and only for non-errored requests; both SHALL be 0 at all other times.
REQ-018 Store: SHALL go to RESP; Resp_Valid = 1 from cycle 1 with Resp_Err = 0 and Resp_RData = 0.
REQ-019 Load: SHALL go to RD_WAIT, count RD_LAT-1 cycles, and capture Mem_Data_R at the end of cycle RD_LAT into Resp_RData; Resp_Valid = 1 from cycle RD_LAT+1.
REQ-020 Errored request: SHALL issue no memory access, go to RESP, and assert Resp_Valid = 1, Resp_Err = 1 and Resp_RData = 0 from cycle 1.
REQ-021 RESP: SHALL hold Resp_Valid, Resp_RData and Resp_Err stable until Resp_Valid & Resp_Ready; then SHALL return to IDLE, with Req_Ready = 1 in the following cycle.
REQ-022 SHALL keep at most one request outstanding; Req_Valid outside IDLE SHALL be ignored.
REQ-023 Err_Count SHALL increment by 1 on each accepted errored request and SHALL saturate at 255.
REQ-024 Load latency from acceptance to Resp_Valid SHALL be RD_LAT+1 cycles; store and error latency SHALL be 1 cycle.

Reset
REQ-025 While Reset = 1, SHALL force Req_Ready = 0, Mem_En_R = 0 and Mem_En_W = 0.
REQ-026 On a Reset edge, SHALL set state = IDLE, Resp_Valid = 0, Resp_Err = 0, Resp_RData = 0, the RD_WAIT counter = 0 and Err_Count = 0.
REQ-027 Reset during RD_WAIT or RESP SHALL discard the in-flight access, and no response SHALL ever be produced for it.

Configuration
REQ-028 Macro MEM_ADDR_CHECK_EN defined: SHALL flag a request as errored when Req_Addr[1:0] != 0 or Req_Addr[31:2] >= DEPTH_WORDS.
REQ-029 Macro MEM_ADDR_CHECK_EN undefined: no request SHALL be errored, Req_Addr[1:0] SHALL be ignored, Resp_Err SHALL be 0 and Err_Count SHALL be 0.

Verification
REQ-030 Store Req_Addr = 0x10, Req_WData = 0xDEADBEEF -> Mem_En_W = 1 and Mem_Addr = 4 in cycle 0; Resp_Valid = 1 and Resp_Err = 0 in cycle 1.
REQ-031 Load 0x10 after that store, RD_LAT = 2 -> Mem_En_R = 1 in cycle 0; Resp_Valid in cycle 3 with Resp_RData = 0xDEADBEEF.
REQ-032 Load with Resp_Ready held low for 5 cycles -> Resp_Valid and Resp_RData stay stable and Req_Ready = 0 throughout; Req_Ready = 1 one cycle after the handshake.
REQ-033 With MEM_ADDR_CHECK_EN: loads at 0x13 and 0x400 (DEPTH_WORDS = 256) -> no memory enables, Resp_Err = 1 each time, Err_Count = 2; 300 errored requests -> Err_Count = 255.
REQ-034 Reset asserted in cycle 1 of a load -> no Resp_Valid is ever produced for it; after reset, Req_Ready = 1 and Err_Count = 0.
REQ-035 Without MEM_ADDR_CHECK_EN: load at 0x13 -> Mem_Addr = 4, Mem_En_R = 1, Resp_Err = 0.
